// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
package seg7_pkg;

   typedef enum logic {
      SCAN_BLANK = 1'b0,
      SCAN_DRIVE = 1'b1
   } scan_state_e;

   // Active-low cathodes: all segments and the dot off.
   localparam logic [7:0] BLANK_PATTERN = 8'hFF;

endpackage

// File: rtl/seg7.sv
// Hex nibble to active-low common-anode 7-segment pattern, {dot, g..a}.
module seg7 (
   input  logic [3:0] hex,
   input  logic       dot,
   output logic [7:0] seg
);

   logic [6:0] gfedcba;

   always_comb begin
      gfedcba = 7'h7F;
      case (hex)
         4'h0: gfedcba = 7'h40;
         4'h1: gfedcba = 7'h79;
         4'h2: gfedcba = 7'h24;
         4'h3: gfedcba = 7'h30;
         4'h4: gfedcba = 7'h19;
         4'h5: gfedcba = 7'h12;
         4'h6: gfedcba = 7'h02;
         4'h7: gfedcba = 7'h78;
         4'h8: gfedcba = 7'h00;
         4'h9: gfedcba = 7'h10;
         4'hA: gfedcba = 7'h08;
         4'hB: gfedcba = 7'h03;
         4'hC: gfedcba = 7'h46;
         4'hD: gfedcba = 7'h21;
         4'hE: gfedcba = 7'h06;
         4'hF: gfedcba = 7'h0E;
      endcase
   end

   assign seg = {~dot, gfedcba};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared
// decoder, with a double-buffered load port that commits at frame boundaries.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [4*NUM_DIGITS-1:0]   value_i,
   input  logic [NUM_DIGITS-1:0]     dots_i,
   input  logic [NUM_DIGITS-1:0]     mask_i,
   input  logic                      load_valid_i,
   output logic                      load_ready_o,
   output logic [NUM_DIGITS-1:0]     anode_o,
   output logic [7:0]                display_o,
   output logic                      frame_tick_o
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] shadow_value, act_value;
   logic [NUM_DIGITS-1:0]   shadow_dots, shadow_mask, act_dots, act_mask;
   logic                    pending;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [IW-1:0]           idx;
   scan_state_e             state;

   logic [NUM_DIGITS-1:0]   anode_p1;
   logic [7:0]              display_p1;
   logic                    tick_p1;

   logic                    slot_end, frame_end;
   logic [3:0]              cur_nibble;
   logic                    cur_dot;
   logic [7:0]              seg_code;

   always_comb begin
      slot_end   = (cnt == CNT_LAST);
      frame_end  = slot_end && (idx == IDX_LAST);
      cnt_nxt    = slot_end ? '0 : cnt + CW'(1);
      cur_nibble = act_value[{idx, 2'b00} +: 4];
      cur_dot    = act_dots[idx];
   end

   seg7 u_seg7 (
      .hex (cur_nibble),
      .dot (cur_dot),
      .seg (seg_code)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt          <= '0;
         idx          <= '0;
         state        <= SCAN_BLANK;
         pending      <= 1'b0;
         shadow_value <= '0;
         shadow_dots  <= '0;
         shadow_mask  <= '0;
         act_value    <= '0;
         act_dots     <= '0;
         act_mask     <= '0;
         anode_p1     <= '1;
         display_p1   <= BLANK_PATTERN;
         tick_p1      <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         state <= (cnt_nxt < BLANK_END) ? SCAN_BLANK : SCAN_DRIVE;
         if (slot_end)
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);

         // A commit frees the shadow; a load arriving on that same edge sees ready low.
         if (frame_end && pending) begin
            act_value <= shadow_value;
            act_dots  <= shadow_dots;
            act_mask  <= shadow_mask;
            pending   <= 1'b0;
         end else if (load_valid_i && !pending) begin
            shadow_value <= value_i;
            shadow_dots  <= dots_i;
            shadow_mask  <= mask_i;
            pending      <= 1'b1;
         end

         // Output stage: one cycle behind {state, idx, cnt}.
         tick_p1 <= frame_end;
         if (state == SCAN_DRIVE && act_mask[idx]) begin
            anode_p1   <= ~(NUM_DIGITS'(1) << idx);
            display_p1 <= seg_code;
         end else begin
            anode_p1   <= '1;
            display_p1 <= BLANK_PATTERN;
         end
      end
   end

   assign load_ready_o = ~pending;
   assign anode_o      = anode_p1;
   assign display_o    = display_p1;
   assign frame_tick_o = tick_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-indexed reference model predicts
// every cycle's outputs; a monitor pops and compares them one cycle later.
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int DIV   = 8;
   localparam int BLK   = 2;
   localparam int FRAME = N * DIV;

   logic          clk;
   logic          rst_n;
   logic [15:0]   value_i;
   logic [3:0]    dots_i;
   logic [3:0]    mask_i;
   logic          load_valid_i;
   logic          load_ready_o;
   logic [3:0]    anode_o;
   logic [7:0]    display_o;
   logic          frame_tick_o;

   seg7_scan_ctrl #(
      .NUM_DIGITS   (N),
      .CLK_DIV      (DIV),
      .BLANK_CYCLES (BLK)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .value_i      (value_i),
      .dots_i       (dots_i),
      .mask_i       (mask_i),
      .load_valid_i (load_valid_i),
      .load_ready_o (load_ready_o),
      .anode_o      (anode_o),
      .display_o    (display_o),
      .frame_tick_o (frame_tick_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] anode;
      logic [7:0] disp;
      logic       tick;
      logic       ready;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Standard active-low g..a patterns for hex 0..F.
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference state: time since reset plus the two buffers.
   int          m_t;
   logic        m_pend;
   logic [15:0] m_sh_val, m_act_val;
   logic [3:0]  m_sh_dots, m_sh_mask, m_act_dots, m_act_mask;

   task automatic model_reset();
      m_t = 0; m_pend = 1'b0;
      m_sh_val = '0; m_sh_dots = '0; m_sh_mask = '0;
      m_act_val = '0; m_act_dots = '0; m_act_mask = '0;
   endtask

   task automatic drive(input logic r, input logic v, input logic [15:0] val,
                        input logic [3:0] d, input logic [3:0] m);
      exp_t e;
      int   pos, slot;
      logic last;
      logic [3:0] nib;
      @(negedge clk);
      rst_n = r; load_valid_i = v; value_i = val; dots_i = d; mask_i = m;
      if (!r) begin
         model_reset();
         e = '{anode: 4'hF, disp: 8'hFF, tick: 1'b0, ready: 1'b1};
      end else begin
         pos  = m_t % DIV;
         slot = (m_t / DIV) % N;
         last = ((m_t % FRAME) == FRAME - 1);
         if (pos < BLK || !m_act_mask[slot]) begin
            e.anode = 4'hF;
            e.disp  = 8'hFF;
         end else begin
            nib     = m_act_val[slot*4 +: 4];
            e.anode = 4'hF & ~(4'b0001 << slot);
            e.disp  = {~m_act_dots[slot], seg_tab[nib]};
         end
         e.tick = last;
         if (last && m_pend) begin
            m_act_val = m_sh_val; m_act_dots = m_sh_dots; m_act_mask = m_sh_mask;
            m_pend = 1'b0;
         end else if (v && !m_pend) begin
            m_sh_val = val; m_sh_dots = d; m_sh_mask = m;
            m_pend = 1'b1;
         end
         e.ready = ~m_pend;
         m_t++;
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
   endtask

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("anode", {4'h0, anode_o}, {4'h0, e.anode});
            check("display", display_o, e.disp);
            check("frame_tick", {7'h0, frame_tick_o}, {7'h0, e.tick});
            check("load_ready", {7'h0, load_ready_o}, {7'h0, e.ready});
         end
      end
   end

   initial begin : stimulus
      logic [31:0] rv;
      rst_n = 1'b0; load_valid_i = 1'b0; value_i = '0; dots_i = '0; mask_i = '0;
      model_reset();

      // Reset, then a dark first frame with a load part way through it.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
      idle(10);
      drive(1'b1, 1'b1, 16'h1234, 4'b0001, 4'hF);
      idle(70);

      // Same value with digit 2 masked off.
      drive(1'b1, 1'b1, 16'h1234, 4'b0001, 4'b1011);
      idle(70);

      // Accepted load followed by a held valid with different data.
      drive(1'b1, 1'b1, 16'h9ABC, 4'b1010, 4'hF);
      for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 16'hE5D0, 4'b0110, 4'hF);
      idle(70);

      // Reset during the DRIVE part of digit 2 with a load pending.
      while (m_pend || (m_t % FRAME) != 18) idle(1);
      drive(1'b1, 1'b1, 16'h8888, 4'hF, 4'hF);
      while ((m_t % FRAME) != 21) idle(1);
      drive(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
      idle(40);

      // Load presented exactly on the commit edge while nothing is pending.
      while (m_pend || (m_t % FRAME) != FRAME - 1) idle(1);
      drive(1'b1, 1'b1, 16'h7F0A, 4'b0100, 4'b1101);
      idle(70);

      // Random traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         rv = $urandom;
         drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0),
               rv[15:0], rv[19:16], rv[23:20]);
      end
      idle(2);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: actual=%0d required=0 entries left", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
